// File: rtl/vm_pkg.sv
// vm_pkg: shared state encoding, entry layout and default sizes for the
// vending-machine product table.
package vm_pkg;

  localparam int DEF_NUM_ITEMS = 8;
  localparam int DEF_PRICE_W   = 7;
  localparam int DEF_STOCK_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } vm_state_t;

  // Stock sits in the LSBs so a table word is {price, stock}.
  typedef struct packed {
    logic [DEF_PRICE_W-1:0] price;
    logic [DEF_STOCK_W-1:0] stock;
  } vm_entry_t;

endpackage

// File: rtl/vm_stock_update.sv
// vm_stock_update: combinational next-stock for one slot. Applies an optional
// restock quantity and a vend request, saturating at the field maximum and
// never going below zero. ack reports whether the vend may be honoured.
module vm_stock_update
  import vm_pkg::*;
#(
  parameter int STOCK_W = DEF_STOCK_W
) (
  input  logic [STOCK_W-1:0] stock_cur,
  input  logic               vend,
  input  logic [STOCK_W-1:0] add_qty,
  output logic [STOCK_W-1:0] stock_nxt,
  output logic               ack
);

  localparam logic [STOCK_W:0] STOCK_MAX = {1'b0, {STOCK_W{1'b1}}};

  logic [STOCK_W:0] sum;
  logic [STOCK_W:0] net;

  // Add first, so a same-cycle restock can cover a vend on an empty slot.
  always_comb begin
    sum       = {1'b0, stock_cur} + {1'b0, add_qty};
    ack       = vend && (sum != '0);
    net       = sum - {{STOCK_W{1'b0}}, ack};
    stock_nxt = (net > STOCK_MAX) ? {STOCK_W{1'b1}} : net[STOCK_W-1:0];
  end

endmodule

// File: rtl/vm_stuff_table.sv
// vm_stuff_table: product table for the vending machine. Entries are streamed
// in after load_start, looked up through a registered read port, and
// decremented by vend requests with a one-cycle ack/nack response.
// Optional restock port enabled by defining VM_STUFF_RESTOCK_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | after reset, table empty, waiting for load_start
// ST_LOAD  | accepting load beats into ascending slots
// ST_READY | table complete, vends (and restocks) allowed
module vm_stuff_table
  import vm_pkg::*;
#(
  parameter  int NUM_ITEMS = DEF_NUM_ITEMS,
  parameter  int PRICE_W   = DEF_PRICE_W,
  parameter  int STOCK_W   = DEF_STOCK_W,
  localparam int IDX_W     = $clog2(NUM_ITEMS),
  localparam int DATA_W    = PRICE_W + STOCK_W
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 load_start,
  input  logic                 load_valid,
  input  logic [DATA_W-1:0]    load_data,
  output logic                 load_ready,
  output logic                 table_valid,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [DATA_W-1:0]    rd_data,
  input  logic                 vend_req,
  input  logic [IDX_W-1:0]     vend_idx,
  output logic                 vend_ack,
  output logic                 vend_nack,
`ifdef VM_STUFF_RESTOCK_EN
  input  logic                 restock_req,
  input  logic [IDX_W-1:0]     restock_idx,
  input  logic [STOCK_W-1:0]   restock_qty,
`endif
  output logic [NUM_ITEMS-1:0] empty_mask
);

  localparam logic [IDX_W:0]   NUM_L    = (IDX_W+1)'(NUM_ITEMS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ITEMS - 1);

  vm_state_t            state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic                 beat_acc;

  logic [DATA_W-1:0]    entry_q [NUM_ITEMS];
  logic [DATA_W-1:0]    entry_d [NUM_ITEMS];
  logic [STOCK_W-1:0]   stock_nxt [NUM_ITEMS];
  logic [STOCK_W-1:0]   add_qty [NUM_ITEMS];
  logic [NUM_ITEMS-1:0] vend_hit;
  logic [NUM_ITEMS-1:0] slot_ack;
  logic [NUM_ITEMS-1:0] empty_d;
  logic                 vend_in_rng;
  logic                 vend_ok;
  logic                 rd_in_rng;
  logic [DATA_W-1:0]    rd_d;
`ifdef VM_STUFF_RESTOCK_EN
  logic                 restock_in_rng;
`endif

  // Next-state, load pointer and status outputs; load_start always wins.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    load_ready  = 1'b0;
    table_valid = 1'b0;
    beat_acc    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
        end
      end
      ST_LOAD: begin
        load_ready = 1'b1;
        if (load_start) begin
          ptr_d = '0;
        end else if (load_valid) begin
          beat_acc = 1'b1;
          if (ptr_q == LAST_IDX) begin
            ptr_d   = '0;
            state_d = ST_READY;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      ST_READY: begin
        table_valid = 1'b1;
        if (load_start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Per-slot decode of vend and restock hits; only READY may touch stock.
  always_comb begin
    vend_in_rng = ({1'b0, vend_idx} < NUM_L);
`ifdef VM_STUFF_RESTOCK_EN
    restock_in_rng = ({1'b0, restock_idx} < NUM_L);
`endif
    for (int i = 0; i < NUM_ITEMS; i++) begin
      vend_hit[i] = vend_req && (state_q == ST_READY) && vend_in_rng &&
                    (vend_idx == IDX_W'(i));
      add_qty[i]  = '0;
`ifdef VM_STUFF_RESTOCK_EN
      if (restock_req && (state_q == ST_READY) && restock_in_rng &&
          (restock_idx == IDX_W'(i)))
        add_qty[i] = restock_qty;
`endif
    end
  end

  for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_slot
    vm_stock_update #(
      .STOCK_W (STOCK_W)
    ) u_upd (
      .stock_cur (entry_q[g][STOCK_W-1:0]),
      .vend      (vend_hit[g]),
      .add_qty   (add_qty[g]),
      .stock_nxt (stock_nxt[g]),
      .ack       (slot_ack[g])
    );
  end

  // At most one slot is hit, so any acking slot means the request is acked.
  assign vend_ok = |(vend_hit & slot_ack);

  // Table update: clear on load_start, else load beat, else stock changes.
  // A vend coinciding with load_start in READY is still answered, but the
  // clear overrides its decrement.
  always_comb begin
    for (int i = 0; i < NUM_ITEMS; i++) begin
      entry_d[i] = entry_q[i];
      if (load_start)
        entry_d[i] = '0;
      else if (beat_acc && (ptr_q == IDX_W'(i)))
        entry_d[i] = load_data;
      else if (state_q == ST_READY)
        entry_d[i][STOCK_W-1:0] = stock_nxt[i];
      empty_d[i] = (entry_d[i][STOCK_W-1:0] == '0);
    end
  end

  // Lookup reads the pre-edge table, so a same-cycle write returns old data.
  always_comb begin
    rd_in_rng = ({1'b0, rd_idx} < NUM_L);
    rd_d      = rd_in_rng ? entry_q[rd_idx] : '0;
  end

  // State, table and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      rd_data    <= '0;
      vend_ack   <= 1'b0;
      vend_nack  <= 1'b0;
      empty_mask <= '1;
      for (int i = 0; i < NUM_ITEMS; i++) entry_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rd_data    <= rd_d;
      vend_ack   <= vend_req && vend_ok;
      vend_nack  <= vend_req && !vend_ok;
      empty_mask <= empty_d;
      for (int i = 0; i < NUM_ITEMS; i++) entry_q[i] <= entry_d[i];
    end
  end

endmodule

// File: tb/tb_vm_stuff_table.sv
// tb_vm_stuff_table: scoreboard bench for vm_stuff_table. Expected outputs are
// queued from a small table model when stimulus is driven and compared one
// cycle later. A second instance with six slots covers out-of-range indices.
module tb_vm_stuff_table;
  import vm_pkg::*;

  localparam int N  = DEF_NUM_ITEMS;
  localparam int PW = DEF_PRICE_W;
  localparam int SW = DEF_STOCK_W;
  localparam int DW = PW + SW;
  localparam int IW = $clog2(N);

  localparam int K_VEND  = 0;
  localparam int K_RD    = 1;
  localparam int K_MASK  = 2;
  localparam int K_TV    = 3;
  localparam int K_LR    = 4;
  localparam int K_VEND6 = 5;
  localparam int K_RD6   = 6;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic          load_start = 1'b0;
  logic          load_valid = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic [IW-1:0] rd_idx = '0;
  logic          vend_req = 1'b0;
  logic [IW-1:0] vend_idx = '0;
  logic          load_ready, table_valid, vend_ack, vend_nack;
  logic [DW-1:0] rd_data;
  logic [N-1:0]  empty_mask;
  logic          load_ready6, table_valid6, vend_ack6, vend_nack6;
  logic [DW-1:0] rd_data6;
  logic [5:0]    empty_mask6;
`ifdef VM_STUFF_RESTOCK_EN
  logic          restock_req = 1'b0;
  logic [IW-1:0] restock_idx = '0;
  logic [SW-1:0] restock_qty = '0;
`endif

  always #5 clock = ~clock;

  vm_stuff_table u_dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .table_valid (table_valid),
    .rd_idx      (rd_idx),
    .rd_data     (rd_data),
    .vend_req    (vend_req),
    .vend_idx    (vend_idx),
    .vend_ack    (vend_ack),
    .vend_nack   (vend_nack),
`ifdef VM_STUFF_RESTOCK_EN
    .restock_req (restock_req),
    .restock_idx (restock_idx),
    .restock_qty (restock_qty),
`endif
    .empty_mask  (empty_mask)
  );

  vm_stuff_table #(.NUM_ITEMS(6)) u_dut6 (
    .clock       (clock),
    .reset_n     (reset_n),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready6),
    .table_valid (table_valid6),
    .rd_idx      (rd_idx),
    .rd_data     (rd_data6),
    .vend_req    (vend_req),
    .vend_idx    (vend_idx),
    .vend_ack    (vend_ack6),
    .vend_nack   (vend_nack6),
`ifdef VM_STUFF_RESTOCK_EN
    .restock_req (restock_req),
    .restock_idx (restock_idx),
    .restock_qty (restock_qty),
`endif
    .empty_mask  (empty_mask6)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int          kind_q[$];
  string       tag_q[$];
  logic [31:0] exp_q[$];

  logic [PW-1:0] m_price [N];
  logic [SW-1:0] m_stock [N];
  logic [PW-1:0] st_price [N];
  logic [SW-1:0] st_stock [N];
  bit            m_ready;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_of(input int k);
    case (k)
      K_VEND:  return 32'({vend_ack, vend_nack});
      K_RD:    return 32'(rd_data);
      K_MASK:  return 32'(empty_mask);
      K_TV:    return 32'(table_valid);
      K_LR:    return 32'(load_ready);
      K_VEND6: return 32'({vend_ack6, vend_nack6});
      K_RD6:   return 32'(rd_data6);
      default: return 32'hdead_beef;
    endcase
  endfunction

  function automatic logic [31:0] m_mask();
    logic [31:0] r = '0;
    for (int i = 0; i < N; i++) r[i] = (m_stock[i] == '0);
    return r;
  endfunction

  function automatic logic [31:0] m_entry(input int i);
    return 32'({m_price[i], m_stock[i]});
  endfunction

  task automatic expect_out(input int k, input string tag, input logic [31:0] v);
    kind_q.push_back(k);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    while (kind_q.size() != 0) begin
      int          k;
      string       t;
      logic [31:0] e;
      k = kind_q.pop_front();
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check_val(t, obs_of(k), e);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_price[i] = '0;
      m_stock[i] = '0;
    end
    m_ready = 1'b0;
  endtask

  task automatic check_reset_vals(input string pfx);
    check_val({pfx, "_load_ready"}, 32'(load_ready), 32'd0);
    check_val({pfx, "_table_valid"}, 32'(table_valid), 32'd0);
    check_val({pfx, "_rd_data"}, 32'(rd_data), 32'd0);
    check_val({pfx, "_vend_resp"}, 32'({vend_ack, vend_nack}), 32'd0);
    check_val({pfx, "_empty_mask"}, 32'(empty_mask), 32'((1 << N) - 1));
  endtask

  // Assert reset away from the clock edge and check outputs before any edge.
  task automatic do_reset(input string pfx);
    reset_n = 1'b0;
    #1;
    check_reset_vals(pfx);
    load_start = 1'b0;
    load_valid = 1'b0;
    vend_req   = 1'b0;
    rd_idx     = '0;
`ifdef VM_STUFF_RESTOCK_EN
    restock_req = 1'b0;
`endif
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    expect_out(K_VEND, {pfx, "_no_resp_a"}, 32'd0);
    step();
    expect_out(K_VEND, {pfx, "_no_resp_b"}, 32'd0);
    expect_out(K_MASK, {pfx, "_mask_post"}, m_mask());
    step();
  endtask

  task automatic start_load(input bit with_junk);
    vend_req   = 1'b0;
    load_start = 1'b1;
    load_valid = with_junk;
    load_data  = '1;
    model_clear();
    expect_out(K_LR, "start_load_ready", 32'd1);
    expect_out(K_TV, "start_table_valid", 32'd0);
    expect_out(K_MASK, "start_mask_cleared", m_mask());
    step();
    load_start = 1'b0;
    load_valid = 1'b0;
  endtask

  task automatic stream(input int first, input int n);
    vm_entry_t e;
    for (int i = first; i < first + n; i++) begin
      m_price[i] = st_price[i];
      m_stock[i] = st_stock[i];
      e.price    = st_price[i];
      e.stock    = st_stock[i];
      load_valid = 1'b1;
      load_data  = e;
      if (i == N - 1) m_ready = 1'b1;
      expect_out(K_TV, "beat_table_valid", 32'(m_ready));
      expect_out(K_LR, "beat_load_ready", 32'(!m_ready));
      expect_out(K_MASK, "beat_mask", m_mask());
      step();
    end
    load_valid = 1'b0;
  endtask

  task automatic load_beats(input int first, input int n, input int pbase, input int stk);
    for (int i = first; i < first + n; i++) begin
      st_price[i] = PW'(pbase + i);
      st_stock[i] = SW'(stk);
    end
    stream(first, n);
  endtask

  task automatic read_all();
    for (int i = 0; i < N; i++) begin
      rd_idx = IW'(i);
      expect_out(K_RD, "rd_slot", m_entry(i));
      step();
    end
  endtask

  // Leaves vend_req high so consecutive calls are back-to-back requests.
  task automatic vend(input int idx);
    bit ok;
    vend_req = 1'b1;
    vend_idx = IW'(idx);
    ok = m_ready && (idx < N) && (m_stock[idx] != '0);
    if (ok) m_stock[idx] = m_stock[idx] - 1'b1;
    expect_out(K_VEND, "vend_resp", 32'({ok, !ok}));
    expect_out(K_MASK, "vend_mask", m_mask());
    step();
  endtask

  task automatic vend_done();
    vend_req = 1'b0;
    expect_out(K_VEND, "vend_idle", 32'd0);
    step();
  endtask

  initial begin
    model_clear();
    #3;
    // Reset and first full load.
    do_reset("rst0");
    start_load(1'b0);
    load_beats(0, N, 5, 3);
    check_val("dut6_table_valid", 32'(table_valid6), 32'd1);
    rd_idx = 3'd2;
    expect_out(K_RD, "rd_slot2", 32'({7'd7, 4'd3}));
    step();
    read_all();

    // Back-to-back vends drain slot 4.
    for (int k = 0; k < 4; k++) vend(4);
    check_val("mask4_after_drain", 32'(empty_mask[4]), 32'd1);
    vend_done();
    read_all();

    // Out-of-range lookup and vend on the six-slot instance.
    rd_idx = 3'd7;
    expect_out(K_RD6, "rd6_idx7", 32'd0);
    expect_out(K_RD, "rd_idx7", m_entry(7));
    step();
    rd_idx = 3'd6;
    expect_out(K_RD6, "rd6_idx6", 32'd0);
    step();
    rd_idx = 3'd5;
    expect_out(K_RD6, "rd6_idx5", 32'({7'd10, 4'd3}));
    step();
    expect_out(K_VEND6, "vend6_oor_nack", 32'b01);
    vend(7);
    vend_done();
    rd_idx = 3'd5;
    expect_out(K_RD6, "rd6_idx5_unchanged", 32'({7'd10, 4'd3}));
    step();

    // Vends before the table is valid are refused and change nothing.
    do_reset("rst1");
    vend(1);
    vend_done();
    read_all();
    start_load(1'b0);
    vend(1);
    vend_done();

    // Restart mid-load, then a full reload with stock 1.
    load_beats(0, 3, 5, 3);
    start_load(1'b1);
    load_beats(0, N, 20, 1);
    read_all();

    // Reset in the middle of a load.
    start_load(1'b0);
    load_beats(0, 3, 40, 2);
    do_reset("rst_mid_load");

    // Reset while a vend response is on the outputs.
    start_load(1'b0);
    load_beats(0, N, 30, 2);
    vend(0);
    do_reset("rst_mid_vend");
    read_all();

`ifdef VM_STUFF_RESTOCK_EN
    // Saturating restock and same-cycle vend plus restock on an empty slot.
    start_load(1'b0);
    for (int i = 0; i < N; i++) begin
      st_price[i] = PW'(50 + i);
      st_stock[i] = (i == 0) ? SW'(14) : (i == 1) ? SW'(0) : SW'(3);
    end
    stream(0, N);
    restock_req = 1'b1;
    restock_idx = 3'd0;
    restock_qty = 4'd5;
    m_stock[0]  = 4'd15;
    expect_out(K_MASK, "restock_sat_mask", m_mask());
    step();
    restock_idx = 3'd1;
    restock_qty = 4'd2;
    vend_req    = 1'b1;
    vend_idx    = 3'd1;
    m_stock[1]  = 4'd1;
    expect_out(K_VEND, "vend_restock_ack", 32'b10);
    expect_out(K_MASK, "vend_restock_mask", m_mask());
    step();
    restock_req = 1'b0;
    vend_done();
    read_all();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
